// File: rtl/llc_arbiter.sv
// llc_arbiter: round-robin share of one 256-bit line memory port between I-cache and D-cache
module llc_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
    state_t         state;
    logic           prio_d;
    logic           lat_we;
    logic [31:0]    lat_addr;
    logic [255:0]   lat_wdata;
    logic           d_win;
    // a simultaneous read+write from the D-cache is issued as a write
    assign d_win       = (d_read | d_write) & (prio_d | ~i_read);
    assign mem_read    = (state != IDLE) & ~lat_we;
    assign mem_write   = (state != IDLE) & lat_we;
    assign mem_address = lat_addr;
    assign mem_wdata   = lat_wdata;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;
    assign i_resp      = (state == GRANT_I) & mem_resp;
    assign d_resp      = (state == GRANT_D) & mem_resp;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio_d    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE) begin
            if (d_win || i_read) begin
                state     <= d_win ? GRANT_D : GRANT_I;
                lat_addr  <= d_win ? d_address : i_address;
                lat_wdata <= d_win ? d_wdata : '0;
                lat_we    <= d_win & d_write;
            end
        end else if (mem_resp) begin
            state  <= IDLE;
            prio_d <= (state == GRANT_I);
        end
    end
endmodule
